// File: rtl/count_job_sequencer.sv
// count_job_sequencer: runs an external 4-bit counter through counting jobs
// (clear, run to target for N laps, stop on the final hit, report done/err).
module count_job_sequencer #(
    parameter int LAP_W = 4
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_mode,
    input  logic             cmd_incr,
    input  logic [3:0]       cmd_target,
    input  logic [LAP_W-1:0] cmd_laps,
    input  logic             hold,
    input  logic             abort,
    output logic             ctr_clear,
    output logic             ctr_mode,
    output logic             ctr_incr,
    output logic             ctr_pause,
    input  logic [3:0]       ctr_count,
    output logic             busy,
    output logic [LAP_W-1:0] lap_cnt,
    output logic             done,
    output logic             err
);
    typedef enum logic [1:0] {IDLE, CLR, RUN, DONE} state_t;
    state_t state, state_n;
    logic [3:0] target, target_n, nxt;
    logic [LAP_W-1:0] laps, laps_n, lap_cnt_n;
    logic clear_n, pause_n, mode_n, incr_n, done_n, err_n, hit, last;

    assign cmd_ready = state == IDLE;
    assign busy      = state != IDLE;

    always_ff @(posedge clk) begin
        if (clear) begin
            state     <= IDLE;
            target    <= '0;
            laps      <= '0;
            lap_cnt   <= '0;
            ctr_clear <= 1'b0;
            ctr_pause <= 1'b1;
            ctr_mode  <= 1'b1;
            ctr_incr  <= 1'b1;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_n;
            target    <= target_n;
            laps      <= laps_n;
            lap_cnt   <= lap_cnt_n;
            ctr_clear <= clear_n;
            ctr_pause <= pause_n;
            ctr_mode  <= mode_n;
            ctr_incr  <= incr_n;
            done      <= done_n;
            err       <= err_n;
        end
    end

    // Predict the counter's value after this edge so the stop lands exactly on target
    always_comb begin
        nxt = ctr_mode ? (ctr_incr ? ctr_count + 4'd1 : ctr_count - 4'd1)
                       : ctr_incr ? (ctr_count == 4'd9 ? 4'd0 : ctr_count + 4'd1)
                                  : (ctr_count == 4'd0 ? 4'd9 : ctr_count - 4'd1);
        hit  = state == RUN && !ctr_pause && nxt == target;
        last = hit && (lap_cnt + LAP_W'(1)) == laps;
        state_n   = state;
        target_n  = target;
        laps_n    = laps;
        lap_cnt_n = lap_cnt;
        clear_n   = 1'b0;
        pause_n   = ctr_pause;
        mode_n    = ctr_mode;
        incr_n    = ctr_incr;
        done_n    = 1'b0;
        err_n     = 1'b0;
        case (state)
            IDLE: begin
                pause_n = 1'b1;
                if (cmd_valid) begin
                    lap_cnt_n = '0;
                    target_n  = cmd_target;
                    laps_n    = cmd_laps == '0 ? LAP_W'(1) : cmd_laps;
                    if (!cmd_mode && cmd_target > 4'd9) begin
                        state_n = DONE;
                        err_n   = 1'b1;
                    end else begin
                        state_n = CLR;
                        clear_n = 1'b1;
                        mode_n  = cmd_mode;
                        incr_n  = cmd_incr;
                    end
                end
            end
            CLR: begin
                pause_n = hold;
                state_n = RUN;
            end
            RUN: begin
                pause_n   = last ? 1'b1 : hold;
                lap_cnt_n = hit ? lap_cnt + LAP_W'(1) : lap_cnt;
                done_n    = last;
                state_n   = last ? DONE : RUN;
            end
            default: begin
                pause_n = 1'b1;
                state_n = IDLE;
            end
        endcase
        // Abort overrides everything, including a coincident final hit
        if (abort && state != IDLE) begin
            state_n   = IDLE;
            pause_n   = 1'b1;
            clear_n   = 1'b0;
            done_n    = 1'b0;
            err_n     = 1'b0;
            lap_cnt_n = lap_cnt;
        end
    end
endmodule

// File: tb/tb_count_job_sequencer.sv
// tb_count_job_sequencer: directed checks of the job sequencer driving a
// behavioural model of the universal counter.
module tb_count_job_sequencer;
    logic clk = 1'b0;
    logic clear, cmd_valid, cmd_ready, cmd_mode, cmd_incr, hold, abort;
    logic [3:0] cmd_target, ctr_count;
    logic [3:0] cmd_laps, lap_cnt;
    logic ctr_clear, ctr_mode, ctr_incr, ctr_pause, busy, done, err;
    int n_chk = 0, n_pass = 0, c;
    bit seen_done;

    count_job_sequencer #(.LAP_W(4)) dut (
        .clk(clk), .clear(clear), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_mode(cmd_mode), .cmd_incr(cmd_incr), .cmd_target(cmd_target),
        .cmd_laps(cmd_laps), .hold(hold), .abort(abort), .ctr_clear(ctr_clear),
        .ctr_mode(ctr_mode), .ctr_incr(ctr_incr), .ctr_pause(ctr_pause),
        .ctr_count(ctr_count), .busy(busy), .lap_cnt(lap_cnt), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        if (clear || ctr_clear) ctr_count <= 4'd0;
        else if (!ctr_pause)
            ctr_count <= ctr_mode ? (ctr_incr ? ctr_count + 4'd1 : ctr_count - 4'd1)
                       : ctr_incr ? (ctr_count == 4'd9 ? 4'd0 : ctr_count + 4'd1)
                                  : (ctr_count == 4'd0 ? 4'd9 : ctr_count - 4'd1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start(input logic m, input logic i, input logic [3:0] t, input logic [3:0] l);
        cmd_valid = 1'b1; cmd_mode = m; cmd_incr = i; cmd_target = t; cmd_laps = l;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int from, output int cyc);
        cyc = from;
        while (!done && cyc < from + 60) begin
            tick();
            cyc++;
        end
    endtask

    initial begin
        clear = 1'b1; cmd_valid = 1'b0; cmd_mode = 1'b0; cmd_incr = 1'b0;
        cmd_target = 4'd0; cmd_laps = 4'd0; hold = 1'b0; abort = 1'b0;
        tick(2);
        check("rst_ready", cmd_ready, 1);
        check("rst_pause", ctr_pause, 1);
        check("rst_clear", ctr_clear, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_lap", lap_cnt, 0);
        check("rst_mode", ctr_mode, 1);
        check("rst_incr", ctr_incr, 1);
        clear = 1'b0;
        tick();

        start(1'b1, 1'b1, 4'd5, 4'd1);
        check("hex_clr_c1", ctr_clear, 1);
        check("hex_busy_c1", busy, 1);
        tick();
        check("hex_cnt_c2", ctr_count, 0);
        check("hex_clr_c2", ctr_clear, 0);
        tick(4);
        check("hex_done_c6", done, 0);
        tick();
        check("hex_cnt_c7", ctr_count, 5);
        check("hex_pause_c7", ctr_pause, 1);
        check("hex_done_c7", done, 1);
        check("hex_lap_c7", lap_cnt, 1);
        tick();
        check("hex_ready_c8", cmd_ready, 1);
        check("hex_cnt_c8", ctr_count, 5);
        check("hex_done_c8", done, 0);

        start(1'b0, 1'b0, 4'd7, 4'd2);
        tick(4);
        check("dec_cnt_c5", ctr_count, 7);
        check("dec_lap_c5", lap_cnt, 1);
        check("dec_mode", ctr_mode, 0);
        tick(8);
        check("dec_cnt_c13", ctr_count, 9);
        tick();
        check("dec_done_c14", done, 0);
        tick();
        check("dec_done_c15", done, 1);
        check("dec_cnt_c15", ctr_count, 7);
        check("dec_lap_c15", lap_cnt, 2);
        tick();

        for (int k = 0; k < 2; k++) begin
            start(1'b1, 1'b1, 4'd0, k == 0 ? 4'd1 : 4'd0);
            wait_done(1, c);
            check(k == 0 ? "wrap_cycle" : "wrap0_cycle", c, 18);
            check(k == 0 ? "wrap_cnt" : "wrap0_cnt", ctr_count, 0);
            check(k == 0 ? "wrap_lap" : "wrap0_lap", lap_cnt, 1);
            tick();
        end

        start(1'b1, 1'b1, 4'd3, 4'd1);
        tick();
        hold = 1'b1;
        tick();
        check("hold_cnt_c3", ctr_count, 1);
        tick(3);
        hold = 1'b0;
        check("hold_cnt_c6", ctr_count, 1);
        check("hold_pause_c6", ctr_pause, 1);
        check("hold_lap_c6", lap_cnt, 0);
        wait_done(6, c);
        check("hold_cycle", c, 9);
        check("hold_cnt_done", ctr_count, 3);
        tick();

        start(1'b0, 1'b1, 4'd12, 4'd1);
        check("err_c1", err, 1);
        check("err_noclr", ctr_clear, 0);
        check("err_ready_c1", cmd_ready, 0);
        check("err_done_c1", done, 0);
        tick();
        check("err_c2", err, 0);
        check("err_ready_c2", cmd_ready, 1);

        start(1'b0, 1'b1, 4'd8, 4'd1);
        tick(4);
        check("ab_cnt_c5", ctr_count, 3);
        hold = 1'b1;
        tick();
        check("ab_cnt_c6", ctr_count, 4);
        hold = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("ab_busy", busy, 0);
        check("ab_pause", ctr_pause, 1);
        check("ab_cnt", ctr_count, 4);
        seen_done = 1'b0;
        for (int k = 0; k < 8; k++) begin
            seen_done |= done;
            tick();
        end
        check("ab_nodone", seen_done, 0);
        check("ab_cnt_late", ctr_count, 4);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
